// File: rtl/sio_pkg.sv
// Shared definitions for the SIO terminal: register word offsets, STAT/CTRL
// bit positions and the shifter state encodings.
package sio_pkg;

   localparam logic [2:0] REG_DATA = 3'd0;
   localparam logic [2:0] REG_STAT = 3'd1;
   localparam logic [2:0] REG_CTRL = 3'd2;
   localparam logic [2:0] REG_BAUD = 3'd3;

   localparam int STAT_RXV = 0;
   localparam int STAT_TXF = 1;
   localparam int STAT_TXE = 2;
   localparam int STAT_OVR = 3;
   localparam int STAT_FE  = 4;

   localparam int CTRL_RXIE = 0;
   localparam int CTRL_TXIE = 1;
   localparam int CTRL_FLOW = 2;

   typedef enum logic {
      TX_IDLE,
      TX_SEND
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/sio_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data.
// A push while full or a pop while empty is ignored.
module sio_fifo #(
   parameter int AW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [7:0]    i_wdata,
   input  logic          i_pop,
   output logic [7:0]    o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;
   logic          w_doPush;
   logic          w_doPop;

   assign o_full   = (r_count == FULL_CNT);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_rdata  = r_mem[r_rdPtr];
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rv_sio_unit.sv
// Memory-mapped 8N1 serial terminal: bus register file, TX/RX FIFOs and the
// bit-level transmit and receive shifters.
module rv_sio_unit
   import sio_pkg::*;
#(
   parameter int FIFO_AW = 4,
   parameter int DIV_RST = 867
) (
   input  logic        clk,
   input  logic        xreset,
   input  logic [4:0]  adr,
   input  logic        cs,
   input  logic        rdy,
   input  logic [3:0]  we,
   input  logic        re,
   output logic        irq,
   input  logic [31:0] dw,
   output logic [31:0] dr,
   output logic        txd,
   input  logic        rxd,
   input  logic        dsr,
   output logic        dtr,
   output logic        txen
);
   localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

   logic        w_wrAcc, w_rdAcc, w_txPush, w_rxPop, w_statClr;
   logic [2:0]  w_word;
   logic [2:0]  r_ctrl;
   logic [15:0] r_baud;
   logic        r_ovr, r_fe;
   logic [31:0] r_dr, w_rdData;
   logic [4:0]  w_stat;
   logic        w_txe;

   logic [7:0]       w_txData, w_rxData;
   logic             w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
   logic [FIFO_AW:0] w_txCount, w_rxCount;

   tx_state_t   r_txState, w_txNext;
   logic        w_txStart, w_txBitEnd;
   logic [9:0]  r_txShift;
   logic [15:0] r_txCnt, r_txDiv;
   logic [3:0]  r_txBit;

   rx_state_t   r_rxState, w_rxNext;
   logic [1:0]  r_rxSync;
   logic        r_rxPrev, w_rxS, w_rxHalfHit, w_rxTake, w_rxDone;
   logic [16:0] w_rxHalf;
   logic [15:0] r_rxCnt, r_rxDiv;
   logic [2:0]  r_rxBit;
   logic [7:0]  r_rxShift;
   logic        w_unused;

   assign w_word    = adr[4:2];
   assign w_wrAcc   = cs & rdy & (|we);
   assign w_rdAcc   = cs & rdy & re;
   assign w_txPush  = w_wrAcc & we[0] & (w_word == REG_DATA);
   assign w_statClr = w_wrAcc & we[0] & (w_word == REG_STAT);
   assign w_rxPop   = w_rdAcc & (w_word == REG_DATA);
   assign w_unused  = ^{adr[1:0], dw[31:16], we[3:2], w_txCount};

   sio_fifo #(.AW(FIFO_AW)) u_txFifo (
      .i_clk   (clk),
      .i_rst_n (xreset),
      .i_push  (w_txPush),
      .i_wdata (dw[7:0]),
      .i_pop   (w_txStart),
      .o_rdata (w_txData),
      .o_full  (w_txFull),
      .o_empty (w_txEmpty),
      .o_count (w_txCount)
   );

   sio_fifo #(.AW(FIFO_AW)) u_rxFifo (
      .i_clk   (clk),
      .i_rst_n (xreset),
      .i_push  (w_rxDone),
      .i_wdata (r_rxShift),
      .i_pop   (w_rxPop),
      .o_rdata (w_rxData),
      .o_full  (w_rxFull),
      .o_empty (w_rxEmpty),
      .o_count (w_rxCount)
   );

   assign w_txe  = w_txEmpty & (r_txState == TX_IDLE);
   assign w_stat = {r_fe, r_ovr, w_txe, w_txFull, ~w_rxEmpty};
   assign irq    = (r_ctrl[CTRL_RXIE] & ~w_rxEmpty) | (r_ctrl[CTRL_TXIE] & w_txe);
   assign dtr    = (w_rxCount != FIFO_DEPTH);
   assign dr     = r_dr;

   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_ctrl <= '0;
         r_baud <= 16'(DIV_RST);
      end else if (w_wrAcc) begin
         if ((w_word == REG_CTRL) && we[0]) begin
            r_ctrl <= dw[2:0];
         end
         if (w_word == REG_BAUD) begin
            if (we[0]) r_baud[7:0]  <= dw[7:0];
            if (we[1]) r_baud[15:8] <= dw[15:8];
         end
      end
   end

   // A flag raised by the receiver in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_ovr <= 1'b0;
         r_fe  <= 1'b0;
      end else begin
         if (w_statClr && dw[STAT_OVR]) r_ovr <= 1'b0;
         if (w_statClr && dw[STAT_FE])  r_fe  <= 1'b0;
         if (w_rxDone && w_rxFull)      r_ovr <= 1'b1;
         if (w_rxDone && !w_rxS)        r_fe  <= 1'b1;
      end
   end

   always_comb begin
      w_rdData = '0;
      case (w_word)
         REG_DATA: if (!w_rxEmpty) w_rdData = {24'd0, w_rxData};
         REG_STAT: w_rdData = {27'd0, w_stat};
         REG_CTRL: w_rdData = {29'd0, r_ctrl};
         REG_BAUD: w_rdData = {16'd0, r_baud};
         default:  w_rdData = '0;
      endcase
   end

   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_dr <= '0;
      end else if (w_rdAcc) begin
         r_dr <= w_rdData;
      end
   end

   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_txState <= TX_IDLE;
      end else begin
         r_txState <= w_txNext;
      end
   end

   always_comb begin
      w_txNext   = r_txState;
      w_txStart  = 1'b0;
      w_txBitEnd = 1'b0;
      case (r_txState)
         TX_IDLE: begin
            if (!w_txEmpty && (!r_ctrl[CTRL_FLOW] || dsr)) begin
               w_txStart = 1'b1;
               w_txNext  = TX_SEND;
            end
         end
         TX_SEND: begin
            if (r_txCnt == r_txDiv) begin
               w_txBitEnd = 1'b1;
               if (r_txBit == 4'd9) w_txNext = TX_IDLE;
            end
         end
         default: w_txNext = TX_IDLE;
      endcase
   end

   // Divisor is re-latched at every bit boundary so BAUD writes never stretch a bit in flight.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_txShift <= '1;
         r_txCnt   <= '0;
         r_txDiv   <= '0;
         r_txBit   <= '0;
      end else if (w_txStart) begin
         r_txShift <= {1'b1, w_txData, 1'b0};
         r_txCnt   <= '0;
         r_txDiv   <= r_baud;
         r_txBit   <= '0;
      end else if (w_txBitEnd) begin
         r_txShift <= {1'b1, r_txShift[9:1]};
         r_txCnt   <= '0;
         r_txDiv   <= r_baud;
         r_txBit   <= r_txBit + 1'b1;
      end else if (r_txState == TX_SEND) begin
         r_txCnt   <= r_txCnt + 1'b1;
      end
   end

   assign txen = (r_txState == TX_SEND);
   assign txd  = (r_txState == TX_SEND) ? r_txShift[0] : 1'b1;

   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_rxSync  <= 2'b11;
         r_rxPrev  <= 1'b1;
         r_rxState <= RX_IDLE;
      end else begin
         r_rxSync  <= {r_rxSync[0], rxd};
         r_rxPrev  <= r_rxSync[1];
         r_rxState <= w_rxNext;
      end
   end

   assign w_rxS       = r_rxSync[1];
   assign w_rxHalf    = ({1'b0, r_rxDiv} + 17'd1) >> 1;
   assign w_rxHalfHit = (({1'b0, r_rxCnt} + 17'd1) >= w_rxHalf);

   always_comb begin
      w_rxNext = r_rxState;
      w_rxTake = 1'b0;
      w_rxDone = 1'b0;
      case (r_rxState)
         RX_IDLE: begin
            if (r_rxPrev && !w_rxS) w_rxNext = RX_START;
         end
         RX_START: begin
            if (w_rxHalfHit) w_rxNext = w_rxS ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (r_rxCnt == r_rxDiv) begin
               w_rxTake = 1'b1;
               if (r_rxBit == 3'd7) w_rxNext = RX_STOP;
            end
         end
         RX_STOP: begin
            if (r_rxCnt == r_rxDiv) begin
               w_rxDone = 1'b1;
               w_rxNext = RX_IDLE;
            end
         end
         default: w_rxNext = RX_IDLE;
      endcase
   end

   // Counter restarts at the mid-start sample so data bits are sampled one full period apart.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         r_rxCnt   <= '0;
         r_rxDiv   <= '0;
         r_rxBit   <= '0;
         r_rxShift <= '0;
      end else if (r_rxState == RX_IDLE) begin
         r_rxCnt   <= '0;
         r_rxDiv   <= r_baud;
         r_rxBit   <= '0;
      end else if ((r_rxState == RX_START) && w_rxHalfHit) begin
         r_rxCnt   <= '0;
      end else if (w_rxTake) begin
         r_rxShift <= {w_rxS, r_rxShift[7:1]};
         r_rxCnt   <= '0;
         r_rxBit   <= r_rxBit + 1'b1;
      end else begin
         r_rxCnt   <= r_rxCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rv_sio_unit.sv
// Self-checking bench for rv_sio_unit: register vectors, serial waveform checks,
// FIFO overflow/framing corner cases and a randomized run against a queue model.
module tb_rv_sio_unit;

   localparam int DIV_RST = 867;
   localparam logic [2:0] W_DATA = 3'd0;
   localparam logic [2:0] W_STAT = 3'd1;
   localparam logic [2:0] W_CTRL = 3'd2;
   localparam logic [2:0] W_BAUD = 3'd3;

   logic        clk = 1'b0;
   logic        xreset = 1'b0;
   logic [4:0]  adr = '0;
   logic        cs = 1'b0;
   logic        rdy = 1'b0;
   logic [3:0]  we = '0;
   logic        re = 1'b0;
   logic        irq;
   logic [31:0] dw = '0;
   logic [31:0] dr;
   logic        txd;
   logic        rxd;
   logic        rxdDrv = 1'b1;
   logic        loopBack = 1'b0;
   logic        dsr = 1'b0;
   logic        dtr;
   logic        txen;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic [2:0]  word;
      logic [3:0]  lanes;
      logic [31:0] wdata;
      logic [31:0] expRead;
      logic        expIrq;
   } regVec_t;

   regVec_t     vecs [12];
   logic [31:0] rdVal;
   logic [7:0]  modelQ [$];
   logic        mOvr = 1'b0;
   logic        mFe = 1'b0;

   assign rxd = loopBack ? txd : rxdDrv;

   rv_sio_unit #(.FIFO_AW(4), .DIV_RST(DIV_RST)) dut (
      .clk    (clk),
      .xreset (xreset),
      .adr    (adr),
      .cs     (cs),
      .rdy    (rdy),
      .we     (we),
      .re     (re),
      .irq    (irq),
      .dw     (dw),
      .dr     (dr),
      .txd    (txd),
      .rxd    (rxd),
      .dsr    (dsr),
      .dtr    (dtr),
      .txen   (txen)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic busWrite(input logic [2:0] word, input logic [3:0] lanes, input logic [31:0] data);
      @(negedge clk);
      adr = {word, 2'b00}; cs = 1'b1; rdy = 1'b1; we = lanes; dw = data; re = 1'b0;
      @(negedge clk);
      cs = 1'b0; we = '0; dw = '0;
   endtask

   task automatic busRead(input logic [2:0] word, output logic [31:0] data);
      @(negedge clk);
      adr = {word, 2'b00}; cs = 1'b1; rdy = 1'b1; we = '0; re = 1'b1;
      @(negedge clk);
      cs = 1'b0; re = 1'b0;
      data = dr;
   endtask

   task automatic applyStimulus(input regVec_t v, input int idx);
      logic [31:0] got;
      busWrite(v.word, v.lanes, v.wdata);
      busRead(v.word, got);
      checkOutput($sformatf("vec%0d read", idx), got, v.expRead);
      checkOutput($sformatf("vec%0d irq", idx), irq, v.expIrq);
   endtask

   // Drives one 8N1 frame at 4 clocks per bit, followed by an idle gap.
   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      logic [9:0] frame;
      frame = {stopBit, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         rxdDrv = frame[i];
         repeat (4) @(negedge clk);
      end
      rxdDrv = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   function automatic logic [31:0] modelStat();
      return {27'd0, mFe, mOvr, 1'b1, 1'b0, (modelQ.size() != 0)};
   endfunction

   task automatic modelPush(input logic [7:0] b, input logic stopBit);
      if (modelQ.size() < 16) modelQ.push_back(b);
      else mOvr = 1'b1;
      if (!stopBit) mFe = 1'b1;
   endtask

   initial begin
      logic        found;
      int          txenCnt;
      logic [39:0] txBits, expWave;
      logic [9:0]  frame;
      logic [7:0]  b;
      logic        stopBit;
      logic [31:0] expData;
      int          op, n;

      vecs[0]  = '{W_CTRL, 4'b0001, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0};
      vecs[1]  = '{W_CTRL, 4'b0001, 32'h0000_0005, 32'h0000_0005, 1'b0};
      vecs[2]  = '{W_CTRL, 4'b1110, 32'h0000_0007, 32'h0000_0005, 1'b0};
      vecs[3]  = '{W_CTRL, 4'b0001, 32'h0000_0002, 32'h0000_0002, 1'b1};
      vecs[4]  = '{W_CTRL, 4'b0001, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[5]  = '{W_BAUD, 4'b0011, 32'hABCD_1234, 32'h0000_1234, 1'b0};
      vecs[6]  = '{W_BAUD, 4'b0010, 32'h0000_5600, 32'h0000_5634, 1'b0};
      vecs[7]  = '{W_BAUD, 4'b1100, 32'hFFFF_FFFF, 32'h0000_5634, 1'b0};
      vecs[8]  = '{3'd5,   4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[9]  = '{3'd7,   4'b0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[10] = '{W_STAT, 4'b0001, 32'h0000_0018, 32'h0000_0004, 1'b0};
      vecs[11] = '{W_BAUD, 4'b0011, 32'h0000_0003, 32'h0000_0003, 1'b0};

      // Reset values, checked both inside and after reset
      repeat (3) @(negedge clk);
      checkOutput("rst txd", txd, 1'b1);
      checkOutput("rst txen", txen, 1'b0);
      checkOutput("rst irq", irq, 1'b0);
      checkOutput("rst dtr", dtr, 1'b1);
      checkOutput("rst dr", dr, 32'h0);
      xreset = 1'b1;
      busRead(W_STAT, rdVal);
      checkOutput("rst STAT", rdVal, 32'h4);
      busRead(W_BAUD, rdVal);
      checkOutput("rst BAUD", rdVal, DIV_RST);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Writes with rdy low are ignored
      @(negedge clk);
      adr = {W_CTRL, 2'b00}; cs = 1'b1; rdy = 1'b0; we = 4'b0001; dw = 32'h7;
      @(negedge clk);
      cs = 1'b0; we = '0; dw = '0;
      busRead(W_CTRL, rdVal);
      checkOutput("rdy0 CTRL", rdVal, 32'h0);

      // TX waveform of 0x55
      busWrite(W_DATA, 4'b0001, 32'h55);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (txen) found = 1'b1;
      end
      checkOutput("tx start", found, 1'b1);
      frame = {1'b1, 8'h55, 1'b0};
      txBits = '0;
      txenCnt = 0;
      for (int i = 0; i < 40; i++) begin
         txBits[i] = txd;
         expWave[i] = frame[i / 4];
         if (txen) txenCnt++;
         @(negedge clk);
      end
      checkOutput("tx wave", txBits, expWave);
      checkOutput("tx txen cycles", txenCnt, 40);
      checkOutput("tx txen after", txen, 1'b0);
      busRead(W_STAT, rdVal);
      checkOutput("tx STAT", rdVal, 32'h4);

      // Loopback of 0xA5
      loopBack = 1'b1;
      busWrite(W_DATA, 4'b0001, 32'hA5);
      repeat (60) @(negedge clk);
      busRead(W_STAT, rdVal);
      checkOutput("loop STAT", rdVal, 32'h5);
      busRead(W_DATA, rdVal);
      checkOutput("loop DATA", rdVal, 32'hA5);
      busRead(W_STAT, rdVal);
      checkOutput("loop STAT empty", rdVal, 32'h4);
      loopBack = 1'b0;

      // Overrun: 17 frames into a 16-deep FIFO
      for (int i = 1; i <= 17; i++) begin
         sendFrame(8'(i), 1'b1);
      end
      busRead(W_STAT, rdVal);
      checkOutput("ovr STAT", rdVal, 32'hD);
      checkOutput("ovr dtr", dtr, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         busRead(W_DATA, rdVal);
         checkOutput($sformatf("ovr DATA%0d", i), rdVal, 32'(i));
      end
      busRead(W_DATA, rdVal);
      checkOutput("ovr DATA empty", rdVal, 32'h0);
      busRead(W_STAT, rdVal);
      checkOutput("ovr STAT drained", rdVal, 32'hC);
      checkOutput("ovr dtr drained", dtr, 1'b1);
      busWrite(W_STAT, 4'b0001, 32'h08);
      busRead(W_STAT, rdVal);
      checkOutput("ovr cleared", rdVal, 32'h4);

      // RX interrupt
      busWrite(W_CTRL, 4'b0001, 32'h1);
      checkOutput("irq idle", irq, 1'b0);
      sendFrame(8'h3C, 1'b1);
      checkOutput("irq set", irq, 1'b1);
      busRead(W_DATA, rdVal);
      checkOutput("irq DATA", rdVal, 32'h3C);
      checkOutput("irq cleared", irq, 1'b0);
      busWrite(W_CTRL, 4'b0001, 32'h0);

      // Framing error and false start
      sendFrame(8'h7E, 1'b0);
      busRead(W_STAT, rdVal);
      checkOutput("fe STAT", rdVal, 32'h15);
      busRead(W_DATA, rdVal);
      checkOutput("fe DATA", rdVal, 32'h7E);
      busWrite(W_STAT, 4'b0001, 32'h10);
      @(negedge clk);
      rxdDrv = 1'b0;
      @(negedge clk);
      rxdDrv = 1'b1;
      repeat (50) @(negedge clk);
      busRead(W_STAT, rdVal);
      checkOutput("glitch STAT", rdVal, 32'h4);
      sendFrame(8'hC3, 1'b1);
      busRead(W_DATA, rdVal);
      checkOutput("after glitch DATA", rdVal, 32'hC3);

      // Flow control holds TX until dsr
      busWrite(W_CTRL, 4'b0001, 32'h4);
      busWrite(W_DATA, 4'b0001, 32'h11);
      repeat (12) @(negedge clk);
      checkOutput("flow hold txen", txen, 1'b0);
      checkOutput("flow hold txd", txd, 1'b1);
      dsr = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("flow go txen", txen, 1'b1);
      repeat (50) @(negedge clk);
      dsr = 1'b0;
      busWrite(W_CTRL, 4'b0001, 32'h0);

      // Randomized frames, reads and clears against a queue model
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 5);
         case (op)
            0, 1: begin
               b = 8'($urandom);
               stopBit = ($urandom_range(0, 7) != 0);
               sendFrame(b, stopBit);
               modelPush(b, stopBit);
            end
            2: begin
               busRead(W_DATA, rdVal);
               expData = (modelQ.size() != 0) ? {24'd0, modelQ.pop_front()} : 32'h0;
               checkOutput($sformatf("rnd%0d DATA", it), rdVal, expData);
            end
            3: begin
               busRead(W_STAT, rdVal);
               checkOutput($sformatf("rnd%0d STAT", it), rdVal, modelStat());
               checkOutput($sformatf("rnd%0d dtr", it), dtr, (modelQ.size() != 16));
            end
            4: begin
               expData = 32'($urandom_range(0, 3)) << 3;
               busWrite(W_STAT, 4'b0001, expData);
               if (expData[3]) mOvr = 1'b0;
               if (expData[4]) mFe = 1'b0;
            end
            default: begin
               n = $urandom_range(1, 3);
               loopBack = 1'b1;
               for (int k = 0; k < n; k++) begin
                  b = 8'($urandom);
                  busWrite(W_DATA, 4'b0001, {24'd0, b});
                  modelPush(b, 1'b1);
               end
               repeat (45 * n + 20) @(negedge clk);
               loopBack = 1'b0;
            end
         endcase
      end
      busRead(W_STAT, rdVal);
      checkOutput("rnd final STAT", rdVal, modelStat());

      // Reset in the middle of a TX frame aborts it at once
      busWrite(W_DATA, 4'b0001, 32'h0F);
      repeat (10) @(negedge clk);
      xreset = 1'b0;
      #1;
      checkOutput("midrst txen", txen, 1'b0);
      checkOutput("midrst txd", txd, 1'b1);
      checkOutput("midrst dr", dr, 32'h0);
      @(negedge clk);
      xreset = 1'b1;
      busRead(W_STAT, rdVal);
      checkOutput("midrst STAT", rdVal, 32'h4);
      busRead(W_BAUD, rdVal);
      checkOutput("midrst BAUD", rdVal, DIV_RST);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
